// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: immediate extension, EX/MEM operand forwarding,
// load-use hazard detection and a registered valid/ready boundary.
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              rd_wr_en,
  input  logic              is_load,
  input  logic [IMM_W-1:0]  imm_in,
  input  logic [1:0]        imm_mode,
  input  logic [DATA_W-1:0] rs1_rdata,
  input  logic [DATA_W-1:0] rs2_rdata,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_wr_en,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_rs1_data,
  output logic [DATA_W-1:0] out_rs2_data,
  output logic [DATA_W-1:0] out_imm,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic              out_rd_wr_en,
  output logic              out_is_load,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int PAD_W = DATA_W - IMM_W;

  function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm,
                                                input logic [1:0] mode);
    logic [DATA_W-1:0] sx;
    sx = {{PAD_W{imm[IMM_W-1]}}, imm};
    case (mode)
      2'b00:   ext_imm = sx;
      2'b01:   ext_imm = {{PAD_W{1'b0}}, imm};
      2'b10:   ext_imm = sx << 1;
      2'b11:   ext_imm = {imm, {PAD_W{1'b0}}};
      default: ext_imm = sx;
    endcase
  endfunction

  // A load in EX has no data yet, so it never forwards; that case is the hazard.
  function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] addr,
                                            input logic [DATA_W-1:0] rdata);
    if (ex_wr_en && !ex_is_load && (ex_rd_addr == addr))
      fwd = ex_result;
    else if (mem_wr_en && (mem_rd_addr == addr))
      fwd = mem_result;
    else
      fwd = rdata;
  endfunction

  logic              out_valid_r;
  logic [DATA_W-1:0] rs1_data_r, rs2_data_r, imm_r;
  logic [REG_AW-1:0] rd_addr_r;
  logic              rd_wr_en_r, is_load_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic              adv_s, xfer_s, hazard_s;

  assign hazard_s = in_valid & out_valid_r & ex_wr_en & ex_is_load &
                    ((ex_rd_addr == rs1_addr) | (ex_rd_addr == rs2_addr));
  assign adv_s    = ~out_valid_r | ex_ready;
  assign in_ready = adv_s & ~hazard_s & ~flush;
  assign xfer_s   = in_valid & in_ready;

  // ID/EX boundary register: flush beats transfer beats bubble beats hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      rs1_data_r  <= {DATA_W{1'b0}};
      rs2_data_r  <= {DATA_W{1'b0}};
      imm_r       <= {DATA_W{1'b0}};
      rd_addr_r   <= {REG_AW{1'b0}};
      rd_wr_en_r  <= 1'b0;
      is_load_r   <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      rs1_data_r  <= fwd(rs1_addr, rs1_rdata);
      rs2_data_r  <= fwd(rs2_addr, rs2_rdata);
      imm_r       <= ext_imm(imm_in, imm_mode);
      rd_addr_r   <= rd_addr;
      rd_wr_en_r  <= rd_wr_en;
      is_load_r   <= is_load;
    end else if (adv_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Saturating count of load-use stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_r <= {CNT_W{1'b0}};
    else if (hazard_s && (stall_cnt_r != {CNT_W{1'b1}}))
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    else
      stall_cnt_r <= stall_cnt_r;
  end

  assign out_valid    = out_valid_r;
  assign out_rs1_data = rs1_data_r;
  assign out_rs2_data = rs2_data_r;
  assign out_imm      = imm_r;
  assign out_rd_addr  = rd_addr_r;
  assign out_rd_wr_en = rd_wr_en_r;
  assign out_is_load  = is_load_r;
  assign hazard_stall = hazard_s;
  assign stall_count  = stall_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for decode/forwarding plus
// hand sequences for load-use, back-pressure, flush, saturation and reset.
module tb_id_ex_stage;

  logic        clk, rst_n, in_valid, in_ready, rd_wr_en, is_load;
  logic [3:0]  rs1_addr, rs2_addr, rd_addr, ex_rd_addr, mem_rd_addr;
  logic [7:0]  imm_in;
  logic [1:0]  imm_mode;
  logic [15:0] rs1_rdata, rs2_rdata, ex_result, mem_result;
  logic        ex_wr_en, ex_is_load, mem_wr_en, flush, ex_ready;
  logic        out_valid, out_rd_wr_en, out_is_load, hazard_stall;
  logic [15:0] out_rs1_data, out_rs2_data, out_imm, stall_count;
  logic [3:0]  out_rd_addr;

  logic        s_in_ready, s_out_valid, s_rd_wr_en, s_is_load, s_hazard;
  logic [15:0] s_rs1, s_rs2, s_imm;
  logic [3:0]  s_rd;
  logic [1:0]  s_count;

  int tests = 0;
  int fails = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rd_wr_en(rd_wr_en), .is_load(is_load), .imm_in(imm_in), .imm_mode(imm_mode),
    .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata), .ex_wr_en(ex_wr_en),
    .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr), .ex_result(ex_result),
    .mem_wr_en(mem_wr_en), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
    .flush(flush), .ex_ready(ex_ready), .out_valid(out_valid),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_rd_addr(out_rd_addr), .out_rd_wr_en(out_rd_wr_en), .out_is_load(out_is_load),
    .hazard_stall(hazard_stall), .stall_count(stall_count)
  );

  id_ex_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rd_wr_en(rd_wr_en), .is_load(is_load), .imm_in(imm_in), .imm_mode(imm_mode),
    .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata), .ex_wr_en(ex_wr_en),
    .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr), .ex_result(ex_result),
    .mem_wr_en(mem_wr_en), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
    .flush(flush), .ex_ready(ex_ready), .out_valid(s_out_valid),
    .out_rs1_data(s_rs1), .out_rs2_data(s_rs2), .out_imm(s_imm),
    .out_rd_addr(s_rd), .out_rd_wr_en(s_rd_wr_en), .out_is_load(s_is_load),
    .hazard_stall(s_hazard), .stall_count(s_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  imm;     logic [1:0]  mode;
    logic [3:0]  rs1;     logic [3:0]  rs2;
    logic [15:0] rd1;     logic [15:0] rd2;
    logic        exw;     logic        exl;
    logic [3:0]  exrd;    logic [15:0] exres;
    logic        memw;    logic [3:0]  memrd;  logic [15:0] memres;
    logic [3:0]  rd;      logic        rdw;    logic        ld;
    logic [15:0] e_rs1;   logic [15:0] e_rs2;  logic [15:0] e_imm;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic w, input logic l, input logic [3:0] a, input logic [15:0] r);
    ex_wr_en = w; ex_is_load = l; ex_rd_addr = a; ex_result = r;
  endtask

  task automatic set_mem(input logic w, input logic [3:0] a, input logic [15:0] r);
    mem_wr_en = w; mem_rd_addr = a; mem_result = r;
  endtask

  initial begin
    //          imm    md     rs1   rs2   rd1       rd2       exw   exl   exrd  exres      memw  memrd memres     rd    rdw   ld    e_rs1      e_rs2      e_imm
    vecs[0] = '{8'h80, 2'b00, 4'd3, 4'd4, 16'h0303, 16'h4444, 1'b1, 1'b0, 4'd3, 16'h1111, 1'b1, 4'd3, 16'h2222, 4'd1, 1'b1, 1'b0, 16'h1111, 16'h4444, 16'hFF80};
    vecs[1] = '{8'h80, 2'b01, 4'd3, 4'd3, 16'h0303, 16'h0303, 1'b0, 1'b0, 4'd3, 16'h1111, 1'b1, 4'd3, 16'h2222, 4'd2, 1'b0, 1'b1, 16'h2222, 16'h2222, 16'h0080};
    vecs[2] = '{8'h80, 2'b10, 4'd3, 4'd1, 16'hA5A5, 16'h0101, 1'b0, 1'b0, 4'd3, 16'h1111, 1'b0, 4'd3, 16'h2222, 4'd3, 1'b1, 1'b1, 16'hA5A5, 16'h0101, 16'hFF00};
    vecs[3] = '{8'h80, 2'b11, 4'd2, 4'd0, 16'h0002, 16'h1234, 1'b1, 1'b1, 4'd9, 16'h9999, 1'b1, 4'd2, 16'h3333, 4'd4, 1'b0, 1'b0, 16'h3333, 16'h1234, 16'h8000};
    vecs[4] = '{8'h7F, 2'b10, 4'd5, 4'd5, 16'h5555, 16'h6666, 1'b0, 1'b0, 4'd5, 16'hDEAD, 1'b0, 4'd5, 16'hBEEF, 4'd5, 1'b1, 1'b0, 16'h5555, 16'h6666, 16'h00FE};
    vecs[5] = '{8'h01, 2'b11, 4'd15, 4'd15, 16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 4'd15, 16'hFFFF, 1'b1, 4'd15, 16'h2222, 4'd15, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0100};

    clk = 1'b0; rst_n = 1'b0;
    in_valid = 1'b0; rs1_addr = 4'd0; rs2_addr = 4'd0; rd_addr = 4'd0;
    rd_wr_en = 1'b0; is_load = 1'b0; imm_in = 8'd0; imm_mode = 2'b00;
    rs1_rdata = 16'd0; rs2_rdata = 16'd0; flush = 1'b0; ex_ready = 1'b1;
    set_ex(1'b0, 1'b0, 4'd0, 16'd0);
    set_mem(1'b0, 4'd0, 16'd0);

    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_rs1", {16'd0, out_rs1_data}, 32'd0);
    chk("rst_imm", {16'd0, out_imm}, 32'd0);
    chk("rst_count", {16'd0, stall_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; imm_in = vecs[i].imm; imm_mode = vecs[i].mode;
      rs1_addr = vecs[i].rs1; rs2_addr = vecs[i].rs2;
      rs1_rdata = vecs[i].rd1; rs2_rdata = vecs[i].rd2;
      set_ex(vecs[i].exw, vecs[i].exl, vecs[i].exrd, vecs[i].exres);
      set_mem(vecs[i].memw, vecs[i].memrd, vecs[i].memres);
      rd_addr = vecs[i].rd; rd_wr_en = vecs[i].rdw; is_load = vecs[i].ld;
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      chk($sformatf("v%0d_hazard", i), {31'd0, hazard_stall}, 32'd0);
      tick();
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_rs1", i), {16'd0, out_rs1_data}, {16'd0, vecs[i].e_rs1});
      chk($sformatf("v%0d_rs2", i), {16'd0, out_rs2_data}, {16'd0, vecs[i].e_rs2});
      chk($sformatf("v%0d_imm", i), {16'd0, out_imm}, {16'd0, vecs[i].e_imm});
      chk($sformatf("v%0d_rd", i), {28'd0, out_rd_addr}, {28'd0, vecs[i].rd});
      chk($sformatf("v%0d_flags", i), {30'd0, out_rd_wr_en, out_is_load},
          {30'd0, vecs[i].rdw, vecs[i].ld});
    end

    // Load-use: EX holds a load to r5, incoming instruction reads r5 via rs2.
    rs1_addr = 4'd1; rs2_addr = 4'd5; rs1_rdata = 16'h0001; rs2_rdata = 16'h0505;
    set_ex(1'b1, 1'b1, 4'd5, 16'h0000);
    set_mem(1'b0, 4'd0, 16'd0);
    #1;
    chk("lu_hazard", {31'd0, hazard_stall}, 32'd1);
    chk("lu_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("lu_bubble", {31'd0, out_valid}, 32'd0);
    chk("lu_count", {16'd0, stall_count}, 32'd1);
    set_ex(1'b0, 1'b0, 4'd0, 16'd0);
    set_mem(1'b1, 4'd5, 16'hBEEF);
    #1;
    chk("lu_hazard_clear", {31'd0, hazard_stall}, 32'd0);
    chk("lu_accept", {31'd0, in_ready}, 32'd1);
    tick();
    chk("lu_valid", {31'd0, out_valid}, 32'd1);
    chk("lu_memfwd", {16'd0, out_rs2_data}, 32'h0000BEEF);
    chk("lu_count_hold", {16'd0, stall_count}, 32'd1);

    // Back-pressure: EX stalls for three cycles, payload must hold.
    set_mem(1'b0, 4'd0, 16'd0);
    rs1_addr = 4'd6; rs1_rdata = 16'h6060; imm_in = 8'h10; imm_mode = 2'b01;
    ex_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_rs2_hold", {16'd0, out_rs2_data}, 32'h0000BEEF);
    end
    ex_ready = 1'b1;
    #1;
    chk("bp_release", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_rs1", {16'd0, out_rs1_data}, 32'h00006060);
    chk("bp_imm", {16'd0, out_imm}, 32'h00000010);

    // Flush with an incoming instruction: rejected, bubble, payload held.
    flush = 1'b1; rs1_rdata = 16'h7070;
    #1;
    chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_payload_hold", {16'd0, out_rs1_data}, 32'h00006060);
    flush = 1'b0;
    tick();
    chk("fl_refill", {31'd0, out_valid}, 32'd1);
    chk("fl_refill_rs1", {16'd0, out_rs1_data}, 32'h00007070);

    // Flush while the stage is held by EX back-pressure.
    in_valid = 1'b0; ex_ready = 1'b0; flush = 1'b1;
    tick();
    chk("fl_held", {31'd0, out_valid}, 32'd0);
    flush = 1'b0; ex_ready = 1'b1; in_valid = 1'b1;
    tick();
    chk("sat_prefill", {31'd0, out_valid}, 32'd1);

    // Hazard held over four cycles by back-pressure; 2-bit counter pins at 3.
    ex_ready = 1'b0; rs1_addr = 4'd5;
    set_ex(1'b1, 1'b1, 4'd5, 16'd0);
    for (int c = 0; c < 4; c++) tick();
    chk("sat_hazard", {31'd0, hazard_stall}, 32'd1);
    chk("cnt16_value", {16'd0, stall_count}, 32'd5);
    chk("cnt2_saturated", {30'd0, s_count}, 32'd3);

    // Asynchronous reset in the middle of the stall.
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {30'd0, out_valid, s_out_valid}, 32'd0);
    chk("ar_payload", {out_rs1_data, out_imm}, 32'd0);
    chk("ar_rs2_rd", {12'd0, out_rd_addr, out_rs2_data}, 32'd0);
    chk("ar_count", {14'd0, s_count, stall_count}, 32'd0);
    chk("ar_hazard", {31'd0, hazard_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_ex(1'b0, 1'b0, 4'd0, 16'd0);
    in_valid = 1'b0; ex_ready = 1'b1;
    tick();
    chk("ar_count_restart", {16'd0, stall_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Parametrised instruction-decode / ID-EX pipeline stage for the pipelined RISC core. It generalises the 16-bit decode path to configurable data and immediate widths, and performs four jobs:
- selectable immediate extension;
- operand forwarding from EX and MEM;
- load-use hazard detection;
- a registered valid/ready ID/EX boundary with stall and flush.

It sits between the register-file read and the ALU/EX stage.

## Interface
Parameters:
- DATA_W, 16, operand/result width; must exceed IMM_W
- IMM_W, 8, raw immediate field width
- REG_AW, 4, register address width
- CNT_W, 16, stall performance-counter width

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- rs1_addr, rs2_addr, rd_addr  in  REG_AW  source/destination registers
- rd_wr_en  in  1  instruction writes rd
- is_load  in  1  instruction is a load
- imm_in  in  IMM_W  raw immediate/offset
- imm_mode  in  2  00 sign-ext, 01 zero-ext, 10 sign-ext then <<1, 11 upper (imm << (DATA_W-IMM_W), low bits 0)
- rs1_rdata, rs2_rdata  in  DATA_W  register-file read data
- ex_wr_en, ex_is_load  in  1  EX-stage instruction writes / is load
- ex_rd_addr  in  REG_AW  EX-stage destination
- ex_result  in  DATA_W  EX-stage ALU result
- mem_wr_en  in  1  MEM-stage instruction writes
- mem_rd_addr  in  REG_AW  MEM-stage destination
- mem_result  in  DATA_W  MEM-stage write-back data
- flush  in  1  squash stage contents (branch taken)
- ex_ready  in  1  EX stage accepts output
- out_valid  out  1  ID/EX register holds valid instruction
- out_rs1_data, out_rs2_data, out_imm  out  DATA_W  registered operands/immediate
- out_rd_addr  out  REG_AW; out_rd_wr_en, out_is_load  out  1
- hazard_stall  out  1  combinational load-use stall indicator
- stall_count  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- Immediate: combinational per imm_mode, width-extended to DATA_W; mode 10 drops the extended MSB.
- Forwarding, per source, highest priority first:
  - EX: ex_wr_en & ~ex_is_load & ex_rd_addr==rsX selects ex_result.
  - MEM: mem_wr_en & mem_rd_addr==rsX selects mem_result.
  - Otherwise the register-file data is used.
- Load-use hazard: hazard_stall = in_valid & out_valid & ex_wr_en & ex_is_load & (ex_rd_addr==rs1_addr | ex_rd_addr==rs2_addr). ex_* describes the instruction currently in EX.
- Handshake:
  - adv = ~out_valid | ex_ready.
  - in_ready = adv & ~hazard_stall & ~flush.
  - Transfer occurs when in_valid & in_ready.
- ID/EX register update, in priority order:
  1. flush: out_valid<=0, payload holds.
  2. transfer: capture forwarded operands, imm, rd, flags; out_valid<=1.
  3. adv without transfer (bubble or hazard): out_valid<=0.
  4. otherwise hold everything.
- stall_count increments by 1 each cycle hazard_stall=1 and saturates at all-ones.
- Upstream must hold its inputs stable while in_valid & ~in_ready.

## Timing
- Reset: out_valid=0, all payload outputs 0, stall_count=0; in_ready evaluates to 1 with out_valid=0.
- Latency: 1 cycle from transfer to out_valid/payload.
- Forwarding sampled in the transfer cycle only; held data is not re-forwarded.
- Load-use: exactly one bubble per hazard, given ex_ready=1. The next cycle the load is in MEM and MEM forwarding supplies the data.
- flush with in_valid=1: the instruction is not accepted (in_ready=0) and the bubble is inserted.
- flush while held (out_valid & ~ex_ready): the held instruction is squashed anyway.
- Reset asserted mid-stall clears state asynchronously; stall_count restarts at 0.

## Test plan
- imm_in=0x80 with modes 00/01/10/11 -> out_imm 0xFF80 / 0x0080 / 0xFF00 / 0x8000.
- Forwarding priority:
  - rs1=3 with EX (rd 3, result 0x1111, non-load) and MEM (rd 3, 0x2222) -> out_rs1_data 0x1111.
  - EX disabled -> 0x2222.
  - Both disabled -> rs1_rdata.
- Load-use: EX is a load to r5, incoming rs2=5 -> hazard_stall=1 and in_ready=0 for one cycle; out_valid=0 next cycle; stall_count=1. The following cycle accepts with MEM forwarding 0xBEEF -> out_rs2_data 0xBEEF.
- Back-pressure: ex_ready=0 for 3 cycles with out_valid=1 -> payload stable, in_ready=0. On ex_ready=1 the next instruction is captured.
- Flush: flush=1 with in_valid=1 -> not accepted, out_valid=0 next cycle; flush while held -> out_valid=0.
- Async reset mid-stall -> all outputs 0 immediately; stall_count saturation checked with CNT_W=2 (stays at 3).
